bar_update_sequencer: RTL and testbench



---
 rtl/bar_update_sequencer_if.sv | 24 ++
 rtl/bar_update_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bar_update_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bar_update_sequencer_if.sv
// Read port from bar_update_sequencer (master) into the FFT spectrum memory (slave).
// spec_lock tells the FFT side that the memory is being read and must not be written.
interface bar_update_sequencer_if #(
    parameter int WIDTH = 12
) ();
    logic           bin_rd;
    logic [7:0]     bin_addr;
    logic [WIDTH:0] bin_data;
    logic           spec_lock;

    modport master (
        output bin_rd,
        output bin_addr,
        output spec_lock,
        input  bin_data
    );

    modport slave (
        input  bin_rd,
        input  bin_addr,
        input  spec_lock,
        output bin_data
    );
endinterface

// File: rtl/bar_update_sequencer.sv
// Per-frame conversion of FFT magnitude bins into 16 smoothed bar heights.
// The new heights reach the renderer only on a vsync rising edge.
module bar_update_sequencer #(
    parameter int WIDTH       = 12,
    parameter int BARS        = 16,
    parameter int USED_BINS   = 69,
    parameter int SCALE_SHIFT = 8
) (
    input  logic                   clk_25MHz,
    input  logic                   rst,
    input  logic                   fft_done,
    input  logic                   vsync,
    bar_update_sequencer_if.master mem,
    output logic [BARS*6-1:0]      bar_height,
    output logic                   frame_swap,
    output logic                   busy
);
    localparam int         IW       = $clog2(BARS);
    localparam logic [7:0] LAST_BIN = 8'(USED_BINS - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, SMOOTH, READY} state_e;

    state_e         state_q, state_d;
    logic [7:0]     addr_q, addr_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           pending_q, pending_d;
    logic [1:0]     vs_q;
    logic           rd_vld_q;
    logic [7:0]     rd_bin_q;
    logic           frame_swap_q;
    logic [6:0]     acc_q    [BARS];
    logic [5:0]     shadow_q [BARS];
    logic [5:0]     bar_q    [BARS];

    logic           vs_rise;
    logic           start;
    logic           swap;
    logic [3:0]     map_bar;
    logic [1:0]     map_k;
    logic [WIDTH:0] scaled;
    logic [6:0]     contrib;
    logic [8:0]     decay_prod;
    logic [5:0]     smooth_val;

    // Log-spaced grouping: returns {k, bar} where k is the extra right shift of the group.
    function automatic logic [5:0] bin_map(input logic [7:0] b);
        logic [3:0] bar;
        logic [1:0] k;
        if (b <= 8'd8) begin
            bar = 4'(b - 8'd1);
            k   = 2'd0;
        end else if (b <= 8'd12) begin
            bar = 4'(8'd8 + ((b - 8'd9) >> 1));
            k   = 2'd0;
        end else if (b <= 8'd20) begin
            bar = 4'(8'd10 + ((b - 8'd13) >> 2));
            k   = 2'd1;
        end else if (b <= 8'd36) begin
            bar = 4'(8'd12 + ((b - 8'd21) >> 3));
            k   = 2'd2;
        end else begin
            bar = 4'(8'd14 + ((b - 8'd37) >> 4));
            k   = 2'd3;
        end
        return {k, bar};
    endfunction

    assign vs_rise = (vs_q == 2'b01);

    always_comb begin
        {map_k, map_bar} = bin_map(rd_bin_q);
        scaled           = mem.bin_data >> SCALE_SHIFT;
        contrib          = 7'(scaled >> map_k);
        decay_prod       = 9'(bar_q[idx_q]) * 9'd7;
        smooth_val       = 6'(acc_q[idx_q] >> 3) + 6'(decay_prod >> 3);
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        pending_d = pending_q | fft_done;
        start     = 1'b0;
        swap      = 1'b0;
        unique case (state_q)
            IDLE:   start = fft_done;
            READ: begin
                addr_d = addr_q + 8'd1;
                if (addr_q == LAST_BIN) state_d = DRAIN;
            end
            DRAIN: begin
                idx_d   = '0;
                state_d = SMOOTH;
            end
            SMOOTH: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(BARS - 1)) state_d = READY;
            end
            READY: begin
                if (vs_rise) begin
                    swap = 1'b1;
                    if (pending_q || fft_done) start   = 1'b1;
                    else                       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Starting a pass consumes any queued request.
        if (start) begin
            state_d   = READ;
            addr_d    = 8'd1;
            pending_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the comb blocks above use blocking.
    always_ff @(posedge clk_25MHz) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst) begin
            vs_q         <= 2'b00;
            rd_vld_q     <= 1'b0;
            rd_bin_q     <= '0;
            frame_swap_q <= 1'b0;
            // NOTE: these arrays are small flop banks, not RAM, so resetting them is legal and cheap.
            for (int i = 0; i < BARS; i++) begin
                acc_q[i]    <= '0;
                shadow_q[i] <= '0;
                bar_q[i]    <= '0;
            end
        end else begin
            vs_q         <= {vs_q[0], vsync};
            rd_vld_q     <= (state_q == READ);
            rd_bin_q     <= addr_q;
            frame_swap_q <= swap;
            if (start) begin
                for (int i = 0; i < BARS; i++) acc_q[i] <= '0;
            end else if (rd_vld_q) begin
                acc_q[map_bar] <= acc_q[map_bar] + contrib;
            end
            if (state_q == SMOOTH) shadow_q[idx_q] <= smooth_val;
            if (swap) bar_q <= shadow_q;
        end
    end

    assign mem.bin_rd    = (state_q == READ);
    assign mem.bin_addr  = (state_q == READ) ? addr_q : 8'd0;
    assign mem.spec_lock = (state_q == READ) || (state_q == DRAIN);
    assign busy          = (state_q != IDLE);
    assign frame_swap    = frame_swap_q;

    for (genvar i = 0; i < BARS; i++) begin : g_pack
        assign bar_height[6*i +: 6] = bar_q[i];
    end
endmodule

// File: tb/tb_bar_update_sequencer.sv
// Self-checking bench for bar_update_sequencer: vector table, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_bar_update_sequencer;
    localparam int WIDTH       = 12;
    localparam int BARS        = 16;
    localparam int USED_BINS   = 69;
    localparam int SCALE_SHIFT = 8;

    typedef logic [WIDTH:0] bin_t;
    typedef struct { int lo; int hi; int bar; int k; } grp_t;
    typedef struct { int lo; int hi; int val; int bar; int exp; } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 fft_done = 1'b0;
    logic                 vsync = 1'b0;
    logic [BARS*6-1:0]    bar_height;
    logic                 frame_swap;
    logic                 busy;

    bin_t ram [0:255];
    int   disp_m [BARS];
    grp_t grp [BARS];
    vec_t vecs [12];
    int   n_checks = 0;
    int   n_errors = 0;

    bar_update_sequencer_if #(.WIDTH(WIDTH)) mem_if ();

    bar_update_sequencer #(
        .WIDTH(WIDTH), .BARS(BARS), .USED_BINS(USED_BINS), .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .clk_25MHz (clk),
        .rst       (rst),
        .fft_done  (fft_done),
        .vsync     (vsync),
        .mem       (mem_if),
        .bar_height(bar_height),
        .frame_swap(frame_swap),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    // One-port memory: data one cycle after the strobe, garbage on idle cycles.
    always @(posedge clk) begin
        if (mem_if.bin_rd) mem_if.bin_data <= ram[mem_if.bin_addr];
        else               mem_if.bin_data <= bin_t'($urandom);
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ctrl();
        return {frame_swap, mem_if.bin_rd, mem_if.spec_lock, busy, mem_if.bin_addr};
    endfunction

    task automatic do_reset();
        rst      = 1'b0;
        fft_done = 1'b0;
        vsync    = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        for (int i = 0; i < BARS; i++) disp_m[i] = 0;
    endtask

    task automatic clear_ram();
        for (int b = 0; b < 256; b++) ram[b] = '0;
    endtask

    task automatic start_frame();
        fft_done = 1'b1;
        step(1);
        fft_done = 1'b0;
    endtask

    // Clean vsync rise; counts frame_swap pulses over a bounded window.
    task automatic do_swap(output int pulses);
        pulses = 0;
        vsync  = 1'b0;
        step(2);
        vsync = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (frame_swap) pulses++;
        end
        vsync = 1'b0;
    endtask

    // Reference: whole-frame grouping from the bin table, then 7/8 smoothing of the shown bars.
    task automatic model_frame();
        int acc [BARS];
        for (int i = 0; i < BARS; i++) acc[i] = 0;
        for (int g = 0; g < BARS; g++)
            for (int b = grp[g].lo; b <= grp[g].hi; b++)
                acc[grp[g].bar] += (int'(ram[b]) >> SCALE_SHIFT) >> grp[g].k;
        for (int i = 0; i < BARS; i++) disp_m[i] = (acc[i] >> 3) + ((disp_m[i] * 7) >> 3);
    endtask

    function automatic logic [95:0] model_vec();
        logic [95:0] v = '0;
        for (int i = 0; i < BARS; i++) v[6*i +: 6] = 6'(disp_m[i]);
        return v;
    endfunction

    initial begin
        int p;
        int cnt;
        logic [95:0] ev;

        for (int i = 0; i < 8; i++) grp[i] = '{i + 1, i + 1, i, 0};
        grp[8]  = '{9, 10, 8, 0};
        grp[9]  = '{11, 12, 9, 0};
        grp[10] = '{13, 16, 10, 1};
        grp[11] = '{17, 20, 11, 1};
        grp[12] = '{21, 28, 12, 2};
        grp[13] = '{29, 36, 13, 2};
        grp[14] = '{37, 52, 14, 3};
        grp[15] = '{53, 68, 15, 3};

        vecs[0]  = '{5, 5, 'h1FFF, 4, 3};
        vecs[1]  = '{37, 52, 'h1FFF, 14, 6};
        vecs[2]  = '{13, 16, 'h0100, 10, 0};
        vecs[3]  = '{9, 10, 'h1FFF, 8, 7};
        vecs[4]  = '{21, 28, 'h1FFF, 12, 7};
        vecs[5]  = '{17, 20, 'h0FFF, 11, 3};
        vecs[6]  = '{1, 1, 'h0800, 0, 1};
        vecs[7]  = '{29, 36, 'h0400, 13, 1};
        vecs[8]  = '{61, 68, 'h1FFF, 15, 3};
        vecs[9]  = '{0, 0, 'h1FFF, 0, 0};
        vecs[10] = '{53, 68, 'h1FFF, 15, 6};
        vecs[11] = '{8, 8, 'h1FFF, 7, 3};

        // Reset held with vsync toggling and a stray fft_done.
        clear_ram();
        for (int c = 0; c < 4; c++) begin
            step(1);
            check("rst_bars", 128'(bar_height), 128'(0));
            check("rst_ctrl", 128'(ctrl()), 128'(0));
            vsync    = ~vsync;
            fft_done = (c == 2);
        end
        fft_done = 1'b0;
        vsync    = 1'b0;
        rst      = 1'b1;
        step(2);
        check("rst_release_idle", 128'(ctrl()), 128'(0));

        // Table-driven single-frame vectors, each from reset.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            clear_ram();
            for (int b = vecs[v].lo; b <= vecs[v].hi; b++) ram[b] = bin_t'(vecs[v].val);
            start_frame();
            step(90);
            do_swap(p);
            check($sformatf("vec%0d_swaps", v), 128'(p), 128'(1));
            ev = '0;
            ev[6*vecs[v].bar +: 6] = 6'(vecs[v].exp);
            check($sformatf("vec%0d_bars", v), 128'(bar_height), 128'(ev));
        end

        // Read timing with bin 5 = 0x1FFF; vsync rises so the rise is seen in cycle 86.
        do_reset();
        clear_ram();
        ram[5] = 'h1FFF;
        start_frame();
        for (int c = 1; c <= 68; c++) begin
            check($sformatf("read_c%0d", c), 128'(ctrl()), 128'({4'b0111, 8'(c)}));
            step(1);
        end
        check("drain_c69", 128'(ctrl()), 128'({4'b0011, 8'd0}));
        step(1);
        for (int c = 70; c <= 85; c++) begin
            check($sformatf("smooth_c%0d", c), 128'(ctrl()), 128'({4'b0001, 8'd0}));
            check($sformatf("smooth_bars_c%0d", c), 128'(bar_height), 128'(0));
            if (c == 85) vsync = 1'b1;
            step(1);
        end
        check("ready_c86", 128'(ctrl()), 128'({4'b0001, 8'd0}));
        check("ready_bars_c86", 128'(bar_height), 128'(0));
        step(1);
        check("swap_c87", 128'(frame_swap), 128'(1));
        ev = '0;
        ev[6*4 +: 6] = 6'd3;
        check("swap_bars_c87", 128'(bar_height), 128'(ev));
        step(1);
        check("swap_pulse_end", 128'(frame_swap), 128'(0));
        check("idle_after_swap", 128'(busy), 128'(0));
        vsync = 1'b0;

        // Identical frame again: 3 + (21 >> 3) = 5.
        start_frame();
        step(90);
        do_swap(p);
        check("repeat_swaps", 128'(p), 128'(1));
        ev[6*4 +: 6] = 6'd5;
        check("repeat_bars", 128'(bar_height), 128'(ev));

        // Tear-free: rise during READ ignored, next rise swaps, a third rise does nothing.
        do_reset();
        clear_ram();
        ram[3] = 'h1FFF;
        start_frame();
        step(10);
        vsync = 1'b0;
        step(2);
        vsync = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (frame_swap) cnt++;
        end
        check("teardrop_no_swap", 128'(cnt), 128'(0));
        check("teardrop_bars", 128'(bar_height), 128'(0));
        vsync = 1'b0;
        step(80);
        do_swap(p);
        model_frame();
        check("tear_swap", 128'(p), 128'(1));
        check("tear_bars", 128'(bar_height), 128'(model_vec()));
        do_swap(p);
        check("tear_second_no_swap", 128'(p), 128'(0));
        check("tear_second_bars", 128'(bar_height), 128'(model_vec()));

        // Pending: three requests in READ collapse into one extra pass, started at the swap.
        do_reset();
        clear_ram();
        ram[2]  = 'h1FFF;
        ram[40] = 'h1FFF;
        start_frame();
        for (int c = 1; c <= 92; c++) begin
            fft_done = (c == 5) || (c == 20) || (c == 40);
            step(1);
        end
        fft_done = 1'b0;
        step(2);
        vsync = 1'b1;
        step(1);
        check("pend_rise_no_swap_yet", 128'(frame_swap), 128'(0));
        step(1);
        check("pend_swap_restart", 128'(ctrl()), 128'({4'b1111, 8'd1}));
        model_frame();
        check("pend_bars1", 128'(bar_height), 128'(model_vec()));
        vsync = 1'b0;
        step(90);
        // fft_done coincides with the rise in READY: swap and restart together.
        vsync = 1'b1;
        step(1);
        fft_done = 1'b1;
        step(1);
        fft_done = 1'b0;
        check("same_cycle_swap_restart", 128'(ctrl()), 128'({4'b1111, 8'd1}));
        model_frame();
        check("same_cycle_bars", 128'(bar_height), 128'(model_vec()));
        vsync = 1'b0;
        step(90);
        do_swap(p);
        model_frame();
        check("pend_final_swap", 128'(p), 128'(1));
        check("pend_final_bars", 128'(bar_height), 128'(model_vec()));
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (mem_if.bin_rd || busy) cnt++;
            step(1);
        end
        check("pend_no_extra_pass", 128'(cnt), 128'(0));

        // Reset at cycle 30 of READ clears outputs on the next cycle.
        check("pre_reset_bars_nonzero", 128'(bar_height != '0), 128'(1));
        start_frame();
        step(29);
        rst = 1'b0;
        step(1);
        check("midrst_ctrl", 128'(ctrl()), 128'(0));
        check("midrst_bars", 128'(bar_height), 128'(0));
        rst = 1'b1;
        step(2);
        check("midrst_idle", 128'(busy), 128'(0));
        do_swap(p);
        check("midrst_no_swap", 128'(p), 128'(0));
        check("midrst_bars_held", 128'(bar_height), 128'(0));
        for (int i = 0; i < BARS; i++) disp_m[i] = 0;

        // Randomized frames against the reference model.
        for (int it = 0; it < 20; it++) begin
            bit extra;
            int swaps;
            for (int b = 0; b < 256; b++) begin
                case ($urandom_range(0, 3))
                    0:       ram[b] = '0;
                    1:       ram[b] = 'h1FFF;
                    default: ram[b] = bin_t'($urandom);
                endcase
            end
            extra = ($urandom_range(0, 3) == 0);
            swaps = 0;
            start_frame();
            for (int c = 1; c <= 60; c++) begin
                vsync    = 1'($urandom_range(0, 1));
                fft_done = extra && (c == 20);
                step(1);
                if (frame_swap) swaps++;
            end
            fft_done = 1'b0;
            vsync    = 1'b0;
            step(30 + $urandom_range(0, 15));
            check($sformatf("rnd%0d_no_swap_busy", it), 128'(swaps), 128'(0));
            do_swap(p);
            model_frame();
            check($sformatf("rnd%0d_swap", it), 128'(p), 128'(1));
            check($sformatf("rnd%0d_bars", it), 128'(bar_height), 128'(model_vec()));
            if (extra) begin
                step(90);
                do_swap(p);
                model_frame();
                check($sformatf("rnd%0d_extra_swap", it), 128'(p), 128'(1));
                check($sformatf("rnd%0d_extra_bars", it), 128'(bar_height), 128'(model_vec()));
            end
            check($sformatf("rnd%0d_idle", it), 128'(busy), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
